// File: rtl/traffic_light_monitor_pkg.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor_pkg
//   Definitions shared by the traffic-light controller's lamp decoder and the
//   far-end traffic_light_monitor, so both ends agree on:
//     - phase encoding (PH_NONE / PH_RED / PH_GREEN / PH_YELLOW)
//     - lamp vector -> phase mapping (anything not one-hot is PH_NONE)
//     - legal phase order R -> G -> Y -> R
//     - per-phase dwell lengths derived from the controller parameters
// ---------------------------------------------------------------------------
package traffic_light_monitor_pkg;

  typedef enum logic [1:0] {
    PH_NONE   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_t;

  // Only a single lit lamp names a phase; dark or multi-lit maps to PH_NONE.
  function automatic phase_t lamp_to_phase(input logic red,
                                           input logic yellow,
                                           input logic green);
    phase_t ph;
    case ({red, yellow, green})
      3'b100:  ph = PH_RED;
      3'b010:  ph = PH_YELLOW;
      3'b001:  ph = PH_GREEN;
      default: ph = PH_NONE;
    endcase
    return ph;
  endfunction

  // Successor of a phase in the R -> G -> Y -> R sequence.
  function automatic phase_t next_phase(input phase_t ph);
    phase_t nx;
    case (ph)
      PH_RED:    nx = PH_GREEN;
      PH_GREEN:  nx = PH_YELLOW;
      PH_YELLOW: nx = PH_RED;
      default:   nx = PH_NONE;
    endcase
    return nx;
  endfunction

  // Dwell length of a phase in clocks. One full R-G-Y cycle spans
  // 2**num_of_bit clocks; red takes whatever green and yellow leave over.
  function automatic int dwell_len(input phase_t ph,
                                   input int     num_of_bit,
                                   input int     green_yellow_ratio,
                                   input int     yellow_len);
    int len;
    case (ph)
      PH_RED:    len = (1 << num_of_bit) - yellow_len * (1 + green_yellow_ratio);
      PH_GREEN:  len = yellow_len * green_yellow_ratio;
      PH_YELLOW: len = yellow_len;
      default:   len = 0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/traffic_light_dwell_checker.sv
// ---------------------------------------------------------------------------
// traffic_light_dwell_checker
//   Saturating dwell counter for the current phase plus comparison against
//   that phase's expected length.
//
//   Ports:
//     CLK        in   clock, rising edge
//     Reset      in   synchronous active-high reset (counter -> 0)
//     clear      in   force counter to 0 (no valid phase)
//     restart    in   new phase starts: counter loads 1
//     advance    in   lamp unchanged this cycle: counter increments
//     phase      in   phase whose length is being measured
//     too_short  out  counter below expected length
//     on_length  out  counter equals expected length
//     too_long   out  strobe: this increment takes the counter to expected+1
// ---------------------------------------------------------------------------
module traffic_light_dwell_checker
  import traffic_light_monitor_pkg::*;
#(
  parameter int num_of_bit         = 4,
  parameter int green_yellow_ratio = 4,
  parameter int yellow_len         = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       clear,
  input  logic       restart,
  input  logic       advance,
  input  logic [1:0] phase,
  output logic       too_short,
  output logic       on_length,
  output logic       too_long
);

  localparam int DW = num_of_bit + 1;

  logic [DW-1:0] dwell;
  logic [DW-1:0] expected;

  always_comb begin
    expected = DW'(dwell_len(phase_t'(phase), num_of_bit, green_yellow_ratio, yellow_len));
  end

  // Saturates at all-ones so an arbitrarily long stuck lamp never wraps
  // back into the legal range.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      dwell <= '0;
    end else if (clear) begin
      dwell <= '0;
    end else if (restart) begin
      dwell <= DW'(1);
    end else if (advance && (dwell != '1)) begin
      dwell <= dwell + 1'b1;
    end
  end

  always_comb begin
    too_short = (dwell < expected);
    on_length = (dwell == expected);
    // Fires on exactly one cycle per phase: the one that passes expected.
    too_long  = advance && (dwell == expected);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor
//   Far-end checker for the Red/Yellow/Green lamp interface. Recovers the
//   current phase and checks lamp encoding, phase order (R->G->Y->R) and
//   per-phase dwell time. Lamps are registered once; all outputs are
//   registered, so a lamp event captured at edge N is reported at edge N+1.
//
//   Ports:
//     CLK          in   clock, rising edge
//     Reset        in   synchronous active-high reset
//     Clear        in   clears sticky Fault (and Cycle_count when present)
//     Red          in   lamp input
//     Yellow       in   lamp input
//     Green        in   lamp input
//     Phase        out  recovered phase: 0 none, 1 red, 2 green, 3 yellow
//     Locked       out  a full checked phase completed since last resync
//     Err_illegal  out  pulse: lamp vector not one-hot
//     Err_order    out  pulse: legal change out of R->G->Y->R order
//     Err_timing   out  pulse: checked phase too short or too long
//     Fault        out  sticky OR of all error pulses
//     Cycle_done   out  pulse: checked Y->R closing a clean checked R,G,Y
//     Cycle_count  out  (TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN only) 8-bit
//                       wrapping count of Cycle_done pulses
//
//   Build option: define TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN to add
//   Cycle_count.
// ---------------------------------------------------------------------------
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int num_of_bit         = 4,
  parameter int green_yellow_ratio = 4,
  parameter int yellow_len         = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Red,
  input  logic       Yellow,
  input  logic       Green,
  output logic [1:0] Phase,
  output logic       Locked,
  output logic       Err_illegal,
  output logic       Err_order,
  output logic       Err_timing,
  output logic       Fault,
  output logic       Cycle_done
`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN
  ,
  output logic [7:0] Cycle_count
`endif
);

  localparam int red_len = (2 ** num_of_bit) - yellow_len * (1 + green_yellow_ratio);

  if (yellow_len < 1) begin : g_bad_yellow_len
    $error("traffic_light_monitor: yellow_len must be >= 1");
  end
  if (red_len < 1) begin : g_bad_red_len
    $error("traffic_light_monitor: derived red_len must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_t;

  function automatic state_t to_state(input phase_t ph);
    state_t st;
    case (ph)
      PH_RED:    st = ST_RED;
      PH_GREEN:  st = ST_GREEN;
      PH_YELLOW: st = ST_YELLOW;
      default:   st = ST_SYNC;
    endcase
    return st;
  endfunction

  state_t     state;
  logic       partial;       // current phase entered mid-way: not timed
  logic       illegal_seen;  // suppresses repeat Err_illegal while in SYNC
  logic [1:0] run_q;         // consecutive clean checked phases, saturating at 3
  logic [2:0] lamp_q;

  phase_t lamp_ph;
  phase_t cur_ph;
  logic   legal;
  logic   same;
  logic   in_order;
  logic   out_of_order;
  logic   cnt_clear;
  logic   cnt_restart;
  logic   cnt_advance;
  logic   too_short;
  logic   on_length;
  logic   too_long;
  logic   phase_clean;
  logic   ill_next;
  logic   ord_next;
  logic   tim_next;
  logic   done_next;

  // Deliberately not reset: the sample taken during reset is what the FSM
  // sees first after release, so a lamp already lit through reset is not
  // mistaken for a dark (illegal) vector.
  always_ff @(posedge CLK) begin
    lamp_q <= {Red, Yellow, Green};
  end

  always_comb begin
    lamp_ph = lamp_to_phase(lamp_q[2], lamp_q[1], lamp_q[0]);
    legal   = (lamp_ph != PH_NONE);

    case (state)
      ST_RED:    cur_ph = PH_RED;
      ST_GREEN:  cur_ph = PH_GREEN;
      ST_YELLOW: cur_ph = PH_YELLOW;
      default:   cur_ph = PH_NONE;
    endcase

    same         = (state != ST_SYNC) && (lamp_ph == cur_ph);
    in_order     = (state != ST_SYNC) && legal && !same && (lamp_ph == next_phase(cur_ph));
    out_of_order = (state != ST_SYNC) && legal && !same && !in_order;

    cnt_clear    = !legal;
    cnt_restart  = legal && !same;
    cnt_advance  = same;

    // A phase that ran its exact length necessarily raised no timing error;
    // an overrun leaves dwell past expected, so on_length is false for it.
    phase_clean  = !partial && on_length;

    ill_next     = !legal && !((state == ST_SYNC) && illegal_seen);
    ord_next     = out_of_order;
    tim_next     = !partial && (too_long || (in_order && too_short));
    // run_q >= 2 at a clean Y->R means the preceding R and G were clean too.
    done_next    = in_order && (state == ST_YELLOW) && phase_clean && (run_q >= 2'd2);
  end

  traffic_light_dwell_checker #(
    .num_of_bit         (num_of_bit),
    .green_yellow_ratio (green_yellow_ratio),
    .yellow_len         (yellow_len)
  ) u_dwell (
    .CLK       (CLK),
    .Reset     (Reset),
    .clear     (cnt_clear),
    .restart   (cnt_restart),
    .advance   (cnt_advance),
    .phase     (cur_ph),
    .too_short (too_short),
    .on_length (on_length),
    .too_long  (too_long)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= ST_SYNC;
      Phase        <= PH_NONE;
      Locked       <= 1'b0;
      Err_illegal  <= 1'b0;
      Err_order    <= 1'b0;
      Err_timing   <= 1'b0;
      Fault        <= 1'b0;
      Cycle_done   <= 1'b0;
      partial      <= 1'b1;
      illegal_seen <= 1'b0;
      run_q        <= '0;
    end else begin
      Err_illegal <= ill_next;
      Err_order   <= ord_next;
      Err_timing  <= tim_next;
      Cycle_done  <= done_next;
      // A new error in the same cycle as Clear wins.
      Fault       <= (Fault && !Clear) || ill_next || ord_next || tim_next;

      if (!legal) begin
        state        <= ST_SYNC;
        Phase        <= PH_NONE;
        Locked       <= 1'b0;
        partial      <= 1'b1;
        illegal_seen <= 1'b1;
        run_q        <= '0;
      end else begin
        illegal_seen <= 1'b0;
        if (state == ST_SYNC) begin
          state   <= to_state(lamp_ph);
          Phase   <= lamp_ph;
          partial <= 1'b1;
          run_q   <= '0;
        end else if (in_order) begin
          state   <= to_state(lamp_ph);
          Phase   <= lamp_ph;
          partial <= 1'b0;
          if (phase_clean) begin
            Locked <= 1'b1;
            if (run_q != 2'd3) begin
              run_q <= run_q + 2'd1;
            end
          end else begin
            run_q <= '0;
          end
        end else if (out_of_order) begin
          state   <= to_state(lamp_ph);
          Phase   <= lamp_ph;
          partial <= 1'b1;
          Locked  <= 1'b0;
          run_q   <= '0;
        end
      end
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN
  always_ff @(posedge CLK) begin
    if (Reset || Clear) begin
      Cycle_count <= '0;
    end else if (done_next) begin
      Cycle_count <= Cycle_count + 8'd1;
    end
  end
`endif

endmodule
